datapath_pipe: RTL
==================

Name: datapath_pipe

Overview:
Parametrised, pipelined successor of the single-issue datapath. It accepts one micro-op per cycle over a valid/ready handshake and runs it through two stages: EX (operand latch, shift, ALU) and C (result hold and writeback). It has a generic-width register file, full operand forwarding, a status-flag register, and result-side backpressure. It sits between the instruction FSM (producer) and the memory/writeback consumer.

Parameters:
WIDTH, 16, datapath word width in bits (>=4)
NREG, 8, number of architectural registers (power of 2, >=2)
RW, $clog2(NREG), register index width (derived, not overridable)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  micro-op present
cmd_ready  out  1  datapath accepts micro-op this cycle
cmd_rn  in  RW  operand A register index
cmd_rm  in  RW  operand B register index (shifted)
cmd_rd  in  RW  destination register index
cmd_shift  in  2  00 none, 01 lsl1, 10 lsr1, 11 asr1 (applied to B)
cmd_aluop  in  2  00 add, 01 sub (A-B), 10 and, 11 not B
cmd_asel  in  1  1: A operand forced to 0
cmd_bsel  in  1  1: B operand = cmd_imm (bypasses shifter)
cmd_imm  in  WIDTH  sign-extended immediate
cmd_wsrc  in  2  writeback source: 00 ALU, 01 cmd_imm, 10 cmd_mdata, 11 zero-extended cmd_pc
cmd_mdata  in  WIDTH  memory data, sampled on accept
cmd_pc  in  9  program counter, sampled on accept
cmd_wb  in  1  write result to cmd_rd
cmd_setf  in  1  update status flags
res_valid  out  1  C stage holds a result
res_ready  in  1  consumer takes result
res_data  out  WIDTH  result word (register C)
res_rd  out  RW  destination of held result
flags  out  3  {Z,V,N} status register

Behaviour:
- Reset (async, rst_n=0): all NREG registers = 0; EX valid = 0; C valid = 0; res_data = 0; res_rd = 0; flags = 0. While in reset, cmd_ready = 0. Reset mid-operation discards all in-flight ops and skips their writeback.
- Advance condition: adv = !res_valid | res_ready. cmd_ready = adv. When adv = 0, both stages hold every register.
- Accept (edge with cmd_valid & cmd_ready): EX latches A = asel ? 0 : fwd(rn), B_raw = fwd(rm), and all control fields plus mdata/pc.
- fwd(r) priority: (1) EX valid & EX.wb & EX.rd==r gives the EX combinational writeback value; (2) C valid & C.wb & C.rd==r gives res_data; (3) otherwise regfile[r]. No hazard stalls exist.
- EX combinational path: sh = shift(B_raw); Bop = bsel ? imm : sh; alu = op(A,Bop) mod 2^WIDTH. Writeback value is the wsrc mux of alu/imm/mdata/{0,pc}.
- Flags are always computed from alu, independent of wsrc:
  - Z = (alu==0)
  - N = alu[WIDTH-1]
  - V = signed overflow for add/sub, else 0
- EX to C on an adv edge: C.valid <= EX.valid; res_data, res_rd, wb, setf and flag values are loaded. EX.valid <= accept.
- Retire: on an edge with res_valid & res_ready:
  - if wb, regfile[res_rd] <= res_data
  - if setf, flags <= held flags
  A result retired with wb=0 only updates flags and the output.
- Latency: accepted at edge E0 → res_valid high from E1 → retired at the first edge with res_ready, at E2 earliest. Sustained throughput is 1 op/cycle with res_ready held high.
- Simultaneous events:
  - Retire-write and operand read of the same register in one cycle: forwarding path (2) supplies the new value.
  - Back-to-back writes to the same rd: the younger value wins via priority (1) and retire order.
- asr1 replicates B_raw[WIDTH-1]; lsr1 and lsl1 fill with 0.
- Backpressure: res_valid stays asserted and res_data stays stable until res_ready. res_data is not cleared after retire.

Test Plan:
- Reset: hold rst_n=0, drive cmd_valid=1 → cmd_ready=0, res_valid=0, flags=000. After release, read r0..r7 via wsrc=ALU, asel=1, aluop=add, rm=rX → every result is 0.
- Forwarding: accept back-to-back r1=imm 0x7FFF; r2=imm 0x0001; r3=r1+r2 with setf, res_ready=1 → third result 0x8000, flags {Z,V,N}=011, r3 reads back 0x8000.
- Zero and sub: r4=r1-r1 with setf → res_data 0x0000, flags=100. Then r5=not r1 with setf → 0x8000, flags=001 (V cleared).
- Backpressure: res_ready=0 for 3 cycles with 2 ops issued → cmd_ready=0 while C is full, res_data held constant, and no regfile/flag change until res_ready=1. Both ops then retire in order.
- Shift and sources: r6 = r0 + asr1(0x8004) → 0xC002. wsrc=mdata 0x1234 → 0x1234. wsrc=pc 0x1FF → 0x01FF. No flag change without setf.
- Reset mid-op: assert rst_n=0 while EX and C are both valid with wb=1 → res_valid drops immediately, and the targeted registers remain 0 after release.

Source files
------------

// File: rtl/datapath_pipe_if.sv
// rtl/datapath_pipe_if.sv - micro-op command, result and status bundle for datapath_pipe
interface datapath_pipe_if #(
  parameter int WIDTH = 16,
  parameter int NREG  = 8
);
  localparam int RW = $clog2(NREG);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [RW-1:0]    cmd_rn;
  logic [RW-1:0]    cmd_rm;
  logic [RW-1:0]    cmd_rd;
  logic [1:0]       cmd_shift;
  logic [1:0]       cmd_aluop;
  logic             cmd_asel;
  logic             cmd_bsel;
  logic [WIDTH-1:0] cmd_imm;
  logic [1:0]       cmd_wsrc;
  logic [WIDTH-1:0] cmd_mdata;
  logic [8:0]       cmd_pc;
  logic             cmd_wb;
  logic             cmd_setf;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic [RW-1:0]    res_rd;
  logic [2:0]       flags;

  modport master (
    output cmd_valid, cmd_rn, cmd_rm, cmd_rd, cmd_shift, cmd_aluop, cmd_asel, cmd_bsel,
           cmd_imm, cmd_wsrc, cmd_mdata, cmd_pc, cmd_wb, cmd_setf, res_ready,
    input  cmd_ready, res_valid, res_data, res_rd, flags
  );

  modport slave (
    input  cmd_valid, cmd_rn, cmd_rm, cmd_rd, cmd_shift, cmd_aluop, cmd_asel, cmd_bsel,
           cmd_imm, cmd_wsrc, cmd_mdata, cmd_pc, cmd_wb, cmd_setf, res_ready,
    output cmd_ready, res_valid, res_data, res_rd, flags
  );
endinterface

// File: rtl/datapath_pipe.sv
// rtl/datapath_pipe.sv - two-stage (EX, C) pipelined datapath with full forwarding
module datapath_pipe #(
  parameter int WIDTH = 16,
  parameter int NREG  = 8
) (
  input logic            clk,
  input logic            rst_n,
  datapath_pipe_if.slave bus
);
  localparam int RW = $clog2(NREG);

  logic [WIDTH-1:0] regfile [NREG];

  logic             ex_valid;
  logic [WIDTH-1:0] ex_a;
  logic [WIDTH-1:0] ex_b_raw;
  logic [RW-1:0]    ex_rd;
  logic [1:0]       ex_shift;
  logic [1:0]       ex_aluop;
  logic             ex_bsel;
  logic [WIDTH-1:0] ex_imm;
  logic [1:0]       ex_wsrc;
  logic [WIDTH-1:0] ex_mdata;
  logic [8:0]       ex_pc;
  logic             ex_wb;
  logic             ex_setf;

  logic             c_valid;
  logic [WIDTH-1:0] c_data;
  logic [RW-1:0]    c_rd;
  logic             c_wb;
  logic             c_setf;
  logic [2:0]       c_flags;
  logic [2:0]       flags_q;

  logic             adv;
  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] bop;
  logic [WIDTH-1:0] alu;
  logic [WIDTH-1:0] wb_val;
  logic             ovf;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;

  assign adv           = !c_valid || bus.res_ready;
  assign bus.cmd_ready = adv && rst_n;
  assign bus.res_valid = c_valid;
  assign bus.res_data  = c_data;
  assign bus.res_rd    = c_rd;
  assign bus.flags     = flags_q;

  always_comb begin
    sh = ex_b_raw;
    case (ex_shift)
      2'b01:   sh = {ex_b_raw[WIDTH-2:0], 1'b0};
      2'b10:   sh = {1'b0, ex_b_raw[WIDTH-1:1]};
      2'b11:   sh = {ex_b_raw[WIDTH-1], ex_b_raw[WIDTH-1:1]};
      default: sh = ex_b_raw;
    endcase
    bop = ex_bsel ? ex_imm : sh;
    alu = '0;
    ovf = 1'b0;
    case (ex_aluop)
      2'b00: begin
        alu = ex_a + bop;
        ovf = (ex_a[WIDTH-1] == bop[WIDTH-1]) && (alu[WIDTH-1] != ex_a[WIDTH-1]);
      end
      2'b01: begin
        alu = ex_a - bop;
        ovf = (ex_a[WIDTH-1] != bop[WIDTH-1]) && (alu[WIDTH-1] != ex_a[WIDTH-1]);
      end
      2'b10:   alu = ex_a & bop;
      default: alu = ~bop;
    endcase
    case (ex_wsrc)
      2'b00:   wb_val = alu;
      2'b01:   wb_val = ex_imm;
      2'b10:   wb_val = ex_mdata;
      default: wb_val = WIDTH'(ex_pc);
    endcase
  end

  // Youngest producer wins: EX result, then the held C result, then the register file.
  function automatic logic [WIDTH-1:0] fwd(input logic [RW-1:0] r);
    if (ex_valid && ex_wb && ex_rd == r)
      return wb_val;
    else if (c_valid && c_wb && c_rd == r)
      return c_data;
    else
      return regfile[r];
  endfunction

  always_comb begin
    opa = bus.cmd_asel ? '0 : fwd(bus.cmd_rn);
    opb = fwd(bus.cmd_rm);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regfile[i] <= '0;
      ex_valid <= 1'b0;
      ex_a     <= '0;
      ex_b_raw <= '0;
      ex_rd    <= '0;
      ex_shift <= '0;
      ex_aluop <= '0;
      ex_bsel  <= 1'b0;
      ex_imm   <= '0;
      ex_wsrc  <= '0;
      ex_mdata <= '0;
      ex_pc    <= '0;
      ex_wb    <= 1'b0;
      ex_setf  <= 1'b0;
      c_valid  <= 1'b0;
      c_data   <= '0;
      c_rd     <= '0;
      c_wb     <= 1'b0;
      c_setf   <= 1'b0;
      c_flags  <= '0;
      flags_q  <= '0;
    end else begin
      if (adv) begin
        ex_valid <= bus.cmd_valid;
        if (bus.cmd_valid) begin
          ex_a     <= opa;
          ex_b_raw <= opb;
          ex_rd    <= bus.cmd_rd;
          ex_shift <= bus.cmd_shift;
          ex_aluop <= bus.cmd_aluop;
          ex_bsel  <= bus.cmd_bsel;
          ex_imm   <= bus.cmd_imm;
          ex_wsrc  <= bus.cmd_wsrc;
          ex_mdata <= bus.cmd_mdata;
          ex_pc    <= bus.cmd_pc;
          ex_wb    <= bus.cmd_wb;
          ex_setf  <= bus.cmd_setf;
        end
        c_valid <= ex_valid;
        // Only a real op replaces the held result, so res_data survives bubbles.
        if (ex_valid) begin
          c_data  <= wb_val;
          c_rd    <= ex_rd;
          c_wb    <= ex_wb;
          c_setf  <= ex_setf;
          c_flags <= {(alu == '0), ovf, alu[WIDTH-1]};
        end
      end
      if (c_valid && bus.res_ready) begin
        if (c_wb) regfile[c_rd] <= c_data;
        if (c_setf) flags_q <= c_flags;
      end
    end
  end
endmodule
